imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  - Writer end of the instruction-memory programming port (write_addr/write_data/w_en).
//  - Takes a byte stream from the UART RX (valid/ready), parses a load frame, packs
//    little-endian bytes into 32-bit words, and issues one-cycle word writes.
//  - Holds the core (cpu_hold) until a complete, valid image is loaded.
// PARAMETERS
//  ADDR_W     14      width of write_addr; byte address, word-aligned
//  BASE_ADDR  14'h0   byte address of the first word written
//  MAGIC      8'hA5   frame start byte
//  MAX_WORDS  4096    largest accepted word count
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  rx_data     in   8       byte from UART receiver
//  rx_valid    in   1       rx_data valid
//  rx_ready    out  1       loader accepts byte; transfer = rx_valid & rx_ready
//  write_addr  out  ADDR_W  imem programming address (bytes, step 4)
//  write_data  out  32      imem programming word
//  w_en        out  1       one-cycle write strobe
//  cpu_hold    out  1       1 = core held (stall/reset) while loading
//  done        out  1       image loaded and accepted
//  error       out  1       frame rejected
// BEHAVIOUR
//  - Reset: write_addr=0, write_data=0, w_en=0, cpu_hold=1, done=0, error=0, rx_ready=0;
//    state=HUNT. rx_ready=1 from first clock after reset release; never drops afterwards.
//  - Frame: MAGIC, CNT_LO, CNT_HI, CNT*4 payload bytes (word LSB first), [CSUM].
//  - FSM: HUNT -> CNT_LO -> CNT_HI -> DATA -> (CSUM) -> DONE; any -> ERR on fault.
//    HUNT: non-MAGIC bytes discarded; MAGIC -> CNT_LO.
//    CNT_HI: CNT=0 -> CSUM (or DONE without checksum); CNT>MAX_WORDS -> ERR.
//    DATA: byte lane = byte_cnt[1:0]; MAGIC value is ordinary data here.
//  - Write timing: 4th byte of a word accepted in cycle N -> w_en=1 in N+1 with
//    write_data = {b3,b2,b1,b0}, write_addr = BASE_ADDR + 4*word_idx (mod 2^ADDR_W).
//    w_en high exactly one cycle per word; no back-pressure from memory.
//  - Word index counts 0..CNT-1; after last word's strobe FSM leaves DATA.
//  - DONE: done=1, cpu_hold=0. A MAGIC byte in DONE or ERR restarts: next cycle
//    done=0, error=0, cpu_hold=1, state=CNT_LO, word_idx=0, checksum cleared.
//  - ERR: error=1, cpu_hold=1, done=0; other bytes ignored. Words already written stay.
//  - Bytes may arrive with arbitrary idle cycles; only transfer cycles advance FSM.
//  - Reset mid-frame: immediate return to reset values; partial word discarded.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - one CSUM byte after payload; expected = XOR of all payload bytes (CNT=0 -> 8'h00).
//    - match -> DONE; mismatch -> ERR. Writes are not retracted.
//  LOADER_CHECKSUM_EN undefined:
//    - no CSUM byte; after last word strobe (or CNT=0) -> DONE. No XOR register.
// TESTING
//  1 A5 02 00 13 00 00 00 93 00 10 00 90 -> w_en twice: (0x0000, 0x00000013), (0x0004, 0x00100093);
//    done=1, cpu_hold=0, error=0.
//  2 Same frame, CSUM=91 (checksum en) -> both writes occur, error=1, cpu_hold=1, done=0.
//  3 00 FF 5A, then frame of test 1, with 0-3 idle cycles between bytes -> identical to test 1.
//  4 A5 00 00 00 -> no w_en, done=1; then A5 -> cpu_hold=1, done=0 next cycle.
//  5 A5 01 10 (CNT=0x1001) -> error=1 after CNT_HI, no w_en; later A5 01 00 .. recovers.
//  6 rst_n low after 6 bytes of test 1 -> reset values, no w_en; re-send -> test 1 result.

Source files
------------

// File: rtl/imem_boot_loader.sv
// UART-fed boot loader: parses MAGIC/CNT/payload frames and writes 32-bit words into imem.
// Optional trailing XOR checksum byte enabled with LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h0,
  parameter logic [7:0]        MAGIC     = 8'hA5,
  parameter int                MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  output logic              w_en,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    HUNT, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

  state_t          state, state_nxt;
  logic [7:0]      cnt_lo;
  logic [15:0]     cnt;
  logic [15:0]     word_idx;
  logic [1:0]      byte_cnt;
  logic [2:0][7:0] word_buf;
  logic            xfer;
  logic [15:0]     cnt_full;
  logic            last_word;
  logic            is_magic;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign xfer      = rx_valid & rx_ready;
  assign cnt_full  = {rx_data, cnt_lo};
  assign last_word = (16'(word_idx + 16'd1) == cnt);
  assign is_magic  = (rx_data == MAGIC);

  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign cpu_hold = (state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      case (state)
        HUNT:   if (is_magic) state_nxt = CNT_LO;
        CNT_LO: state_nxt = CNT_HI;
        CNT_HI: begin
          if (cnt_full == 16'd0)
`ifdef LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          else if ({1'b0, cnt_full} > MAX_CNT)
            state_nxt = ERR;
          else
            state_nxt = DATA;
        end
        DATA: begin
          if (byte_cnt == 2'd3 && last_word)
`ifdef LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM:   state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
        DONE, ERR: if (is_magic) state_nxt = CNT_LO;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Datapath: the 4th byte of a word registers the write, so w_en lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      w_en       <= 1'b0;
      cnt_lo     <= '0;
      cnt        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      rx_ready <= 1'b1;
      w_en     <= 1'b0;
      if (xfer) begin
        case (state)
          HUNT, DONE, ERR: begin
            if (is_magic) begin
              word_idx <= '0;
              byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
              csum     <= '0;
`endif
            end
          end
          CNT_LO: cnt_lo <= rx_data;
          CNT_HI: cnt    <= cnt_full;
          DATA: begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            byte_cnt <= 2'(byte_cnt + 2'd1);
            case (byte_cnt)
              2'd0: word_buf[0] <= rx_data;
              2'd1: word_buf[1] <= rx_data;
              2'd2: word_buf[2] <= rx_data;
              default: begin
                w_en       <= 1'b1;
                write_data <= {rx_data, word_buf[2], word_buf[1], word_buf[0]};
                write_addr <= ADDR_W'(BASE_ADDR + ADDR_W'({word_idx, 2'b00}));
                word_idx   <= 16'(word_idx + 16'd1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
